// File: rtl/count_checker.sv
// ---------------------------------------------------------------------------
// count_checker
//
// Receive-side checker for a BITS-wide up/down counter that runs on an
// unrelated clock. The observed count bus and direction select are
// synchronised into clk. Every accepted change of the count is checked
// against the expected +/-1 modulo step. The block reports steps, counter
// resets (a jump to 0) and sequence errors.
//
// Optional feature (compile-time macro):
//   COUNT_CHECK_GLITCH_FILTER_EN
//     Defined:   a synchronised count is accepted only when it equals the
//                synchronised value of the previous cycle. This rejects
//                multi-bit skew. Latency is SYNC_STAGES+2 edges.
//     Undefined: any synchronised count that differs from last_value is
//                accepted at once. Latency is SYNC_STAGES+1 edges.
//
// Parameters:
//   BITS        width of the observed count bus
//   SYNC_STAGES synchroniser depth, legal range 2..3
//   ERR_W       width of the saturating error counter
//
// Ports:
//   clk        block clock
//   rst_n      asynchronous active-low reset
//   ena        0 = FSM and counters hold; synchroniser and filter keep running
//   count_in   observed count (asynchronous to clk)
//   dir_in     observed direction (asynchronous); 0 = up, 1 = down
//   clear      synchronous; zeroes err_count and forces ACQUIRE
//   locked     high while the FSM is in LOCKED
//   step       one-cycle pulse per valid +/-1 step accepted in LOCKED
//   err        one-cycle pulse per invalid change accepted in LOCKED
//   rst_seen   one-cycle pulse when a jump to 0 is taken as a counter reset
//   err_count  saturating count of err pulses
//   last_value most recently accepted count
//   dbg_state  FSM state for observation: 0 ACQUIRE, 1 VERIFY, 2 LOCKED
//
// There is no valid/ready handshake. The inputs are free-running levels, and
// the outputs are registered levels and single-cycle pulses.
// ---------------------------------------------------------------------------
module count_checker #(
  parameter int BITS        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [BITS-1:0]  count_in,
  input  logic             dir_in,
  input  logic             clear,
  output logic             locked,
  output logic             step,
  output logic             err,
  output logic             rst_seen,
  output logic [ERR_W-1:0] err_count,
  output logic [BITS-1:0]  last_value,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_VERIFY  = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [BITS-1:0]  CNT_ONE = BITS'(1);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  // -------------------------------------------------------------------------
  // Synchronisers. Stage 0 samples the pin; stage SYNC_STAGES-1 is the
  // value used inside the clock domain.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][BITS-1:0] cnt_sync_q;
  logic [SYNC_STAGES-1:0]           dir_sync_q;
  logic [BITS-1:0]                  cnt_s;
  logic                             dir_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_sync_q <= '0;
      dir_sync_q <= '0;
    end else begin
      cnt_sync_q <= {cnt_sync_q[SYNC_STAGES-2:0], count_in};
      dir_sync_q <= {dir_sync_q[SYNC_STAGES-2:0], dir_in};
    end
  end

  assign cnt_s = cnt_sync_q[SYNC_STAGES-1];
  assign dir_s = dir_sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // FSM state and registered outputs
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [BITS-1:0]  last_q, last_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             rst_seen_q, rst_seen_d;
  logic             dir_ref_q;   // direction the FSM last acted on
  logic [BITS-1:0]  expected;
  logic             accept;

  // -------------------------------------------------------------------------
  // Acceptance
  // -------------------------------------------------------------------------
`ifdef COUNT_CHECK_GLITCH_FILTER_EN
  logic [BITS-1:0] cnt_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_prev_q <= '0;
    end else begin
      cnt_prev_q <= cnt_s;
    end
  end

  // A value is accepted only after it has held for two consecutive cycles,
  // so a skewed multi-bit transition never reaches the FSM. A stable value
  // equal to last_value is also "accepted", but the FSM takes no action on it.
  assign accept = (cnt_s == cnt_prev_q);
`else
  assign accept = (cnt_s != last_q);
`endif

  // Modulo arithmetic wraps naturally: 15+1 = 0 and 0-1 = 15 for BITS = 4.
  assign expected = dir_s ? (last_q - CNT_ONE) : (last_q + CNT_ONE);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    err_cnt_d  = err_cnt_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    rst_seen_d = 1'b0;

    if (clear) begin
      state_d   = ST_ACQUIRE;
      err_cnt_d = '0;
    end else if (ena) begin
      if (dir_s != dir_ref_q) begin
        // A direction change invalidates the lock. The value is kept.
        state_d = ST_VERIFY;
      end else if (accept) begin
        case (state_q)
          ST_ACQUIRE: begin
            last_d  = cnt_s;
            state_d = ST_VERIFY;
          end
          ST_VERIFY: begin
            if (cnt_s == expected) begin
              last_d  = cnt_s;
              state_d = ST_LOCKED;
            end else if (cnt_s != last_q) begin
              last_d = cnt_s;
            end
          end
          ST_LOCKED: begin
            if (cnt_s == last_q) begin
              // no change
            end else if (cnt_s == expected) begin
              step_d = 1'b1;
              last_d = cnt_s;
            end else if (cnt_s == '0) begin
              // A jump to zero that is not a legal step is taken as a reset
              // of the remote counter.
              rst_seen_d = 1'b1;
              last_d     = '0;
              state_d    = ST_VERIFY;
            end else begin
              err_d   = 1'b1;
              last_d  = cnt_s;
              state_d = ST_VERIFY;
              if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
              end
            end
          end
          default: state_d = ST_ACQUIRE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACQUIRE;
      last_q     <= '0;
      err_cnt_q  <= '0;
      locked_q   <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      rst_seen_q <= 1'b0;
      dir_ref_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      err_cnt_q  <= err_cnt_d;
      locked_q   <= (state_d == ST_LOCKED);
      step_q     <= step_d;
      err_q      <= err_d;
      rst_seen_q <= rst_seen_d;
      // The direction reference follows the FSM. While ena is low it holds,
      // so a direction change during that time is still seen later.
      if (clear || ena) begin
        dir_ref_q <= dir_s;
      end
    end
  end

  assign locked     = locked_q;
  assign step       = step_q;
  assign err        = err_q;
  assign rst_seen   = rst_seen_q;
  assign err_count  = err_cnt_q;
  assign last_value = last_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_count_checker.sv
`timescale 1ns/1ps
module tb_count_checker;

  localparam int HOLD = 8;
`ifdef COUNT_CHECK_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int S_ACQ = 0;
  localparam int S_VER = 1;
  localparam int S_LCK = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] count_in;
  logic       dir_in;
  logic       clear;
  logic       locked;
  logic       step;
  logic       err;
  logic       rst_seen;
  logic [7:0] err_count;
  logic [3:0] last_value;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  count_checker #(.BITS(4), .SYNC_STAGES(2), .ERR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .count_in   (count_in),
    .dir_in     (dir_in),
    .clear      (clear),
    .locked     (locked),
    .step       (step),
    .err        (err),
    .rst_seen   (rst_seen),
    .err_count  (err_count),
    .last_value (last_value),
    .dbg_state  (dbg_state)
  );

  // ---------------- vector records ----------------
  typedef struct packed {
    logic [1:0] n_step;
    logic [1:0] n_err;
    logic [1:0] n_rst;
    logic       locked;
    logic [3:0] last;
    logic [7:0] err_cnt;
    logic [1:0] state;
  } exp_t;

  typedef struct packed {
    logic [3:0] cnt;
    logic       dir;
    logic       en;
    exp_t       want;
  } vec_t;

  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  vec_t             vecs[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int c, input int d, input int en,
                              input int ns, input int ne, input int nr,
                              input int lk, input int lst, input int ec,
                              input int st);
    vec_t v;
    v.cnt          = 4'(c);
    v.dir          = 1'(d);
    v.en           = 1'(en);
    v.want.n_step  = 2'(ns);
    v.want.n_err   = 2'(ne);
    v.want.n_rst   = 2'(nr);
    v.want.locked  = 1'(lk);
    v.want.last    = 4'(lst);
    v.want.err_cnt = 8'(ec);
    v.want.state   = 2'(st);
    return v;
  endfunction

  // ---------------- driver ----------------
  // Drives one record, holds it HOLD cycles while counting pulses, then
  // compares against the expected record taken from the queue.
  task automatic apply(input vec_t v, input string tag);
    exp_t want;
    int   ns;
    int   ne;
    int   nr;
    ns = 0;
    ne = 0;
    nr = 0;
    @(negedge clk);
    count_in = v.cnt;
    dir_in   = v.dir;
    ena      = v.en;
    exp_q.push_back(v.want);
    repeat (HOLD) begin
      @(posedge clk);
      #1;
      ns += int'(step);
      ne += int'(err);
      nr += int'(rst_seen);
    end
    want = exp_t'(exp_q.pop_front());
    chk($sformatf("%s step_pulses", tag), ns, int'(want.n_step));
    chk($sformatf("%s err_pulses", tag), ne, int'(want.n_err));
    chk($sformatf("%s rst_seen_pulses", tag), nr, int'(want.n_rst));
    chk($sformatf("%s locked", tag), int'(locked), int'(want.locked));
    chk($sformatf("%s last_value", tag), int'(last_value), int'(want.last));
    chk($sformatf("%s err_count", tag), int'(err_count), int'(want.err_cnt));
    chk($sformatf("%s state", tag), int'(dbg_state), int'(want.state));
  endtask

  task automatic chk_all_reset(input string tag);
    chk($sformatf("%s locked", tag), int'(locked), 0);
    chk($sformatf("%s step", tag), int'(step), 0);
    chk($sformatf("%s err", tag), int'(err), 0);
    chk($sformatf("%s rst_seen", tag), int'(rst_seen), 0);
    chk($sformatf("%s err_count", tag), int'(err_count), 0);
    chk($sformatf("%s last_value", tag), int'(last_value), 0);
    chk($sformatf("%s state", tag), int'(dbg_state), S_ACQ);
  endtask

  // ---------------- test ----------------
  initial begin
    int m_last;
    int m_err;
    int v1;
    int v2;

    rst_n    = 1'b0;
    ena      = 1'b1;
    dir_in   = 1'b0;
    clear    = 1'b0;
    count_in = 4'd0;

    // count, dir, ena, step, err, rst_seen, locked, last, err_count, state
    vecs.push_back(mk(3, 0, 1, 0, 0, 0, 0, 3, 0, S_VER));
    vecs.push_back(mk(4, 0, 1, 0, 0, 0, 1, 4, 0, S_LCK));
    vecs.push_back(mk(5, 0, 1, 1, 0, 0, 1, 5, 0, S_LCK));
    for (int c = 6; c <= 15; c++) vecs.push_back(mk(c, 0, 1, 1, 0, 0, 1, c, 0, S_LCK));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, S_LCK));    // 15 -> 0 up
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1, 1, 0, S_LCK));
    vecs.push_back(mk(2, 0, 1, 1, 0, 0, 1, 2, 0, S_LCK));
    vecs.push_back(mk(2, 1, 1, 0, 0, 0, 0, 2, 0, S_VER));    // dir change
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 0, S_LCK));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 0, S_LCK));
    vecs.push_back(mk(15, 1, 1, 1, 0, 0, 1, 15, 0, S_LCK));  // 0 -> 15 down
    vecs.push_back(mk(14, 1, 1, 1, 0, 0, 1, 14, 0, S_LCK));
    vecs.push_back(mk(14, 0, 1, 0, 0, 0, 0, 14, 0, S_VER));  // dir back up
    vecs.push_back(mk(15, 0, 1, 0, 0, 0, 1, 15, 0, S_LCK));
    for (int c = 0; c <= 9; c++) vecs.push_back(mk(c, 0, 1, 1, 0, 0, 1, c, 0, S_LCK));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, S_VER));    // 9 -> 0 reset
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 0, S_LCK));
    vecs.push_back(mk(2, 0, 1, 1, 0, 0, 1, 2, 0, S_LCK));
    for (int c = 3; c <= 6; c++) vecs.push_back(mk(c, 0, 1, 1, 0, 0, 1, c, 0, S_LCK));
    vecs.push_back(mk(11, 0, 1, 0, 1, 0, 0, 11, 1, S_VER));  // 6 -> 11 error

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // error counter saturation: lock on +1, then jump +5 (never to 0)
    m_last = 11;
    m_err  = 1;
    for (int it = 0; it < 259; it++) begin
      v1 = (m_last + 1) % 16;
      apply(mk(v1, 0, 1, 0, 0, 0, 1, v1, m_err, S_LCK), $sformatf("sat_lock%0d", it));
      v2 = (v1 + 5) % 16;
      if (v2 == 0) v2 = (v1 + 6) % 16;
      m_err = (m_err < 255) ? m_err + 1 : 255;
      apply(mk(v2, 0, 1, 0, 1, 0, 0, v2, m_err, S_VER), $sformatf("sat_err%0d", it));
      m_last = v2;
    end

    // direction toggle while locked (last value is 13 after the loop)
    apply(mk(11, 0, 1, 0, 0, 0, 0, 11, 255, S_VER), "dir_pre");
    apply(mk(12, 0, 1, 0, 0, 0, 1, 12, 255, S_LCK), "dir_lock");
    apply(mk(12, 1, 1, 0, 0, 0, 0, 12, 255, S_VER), "dir_toggle");
    apply(mk(11, 1, 1, 0, 0, 0, 1, 11, 255, S_LCK), "dir_relock");
    apply(mk(10, 1, 1, 1, 0, 0, 1, 10, 255, S_LCK), "dir_step");

    // one-cycle clear
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk("clear err_count", int'(err_count), 0);
    chk("clear state", int'(dbg_state), S_ACQ);
    chk("clear locked", int'(locked), 0);
    chk("clear step", int'(step), 0);
    @(negedge clk);
    clear = 1'b0;

    apply(mk(5, 1, 1, 0, 0, 0, 0, 5, 0, S_VER), "post_clear");
    apply(mk(4, 1, 1, 0, 0, 0, 1, 4, 0, S_LCK), "post_clear_lock");
    apply(mk(3, 1, 0, 0, 0, 0, 1, 4, 0, S_LCK), "ena_off");
    apply(mk(3, 1, 1, 1, 0, 0, 1, 3, 0, S_LCK), "ena_on");

    // latency of a single step, counted in rising edges
    @(negedge clk);
    count_in = 4'd2;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      if (k < LAT) begin
        chk($sformatf("lat edge%0d step", k), int'(step), 0);
        chk($sformatf("lat edge%0d last_value", k), int'(last_value), 3);
      end else begin
        chk($sformatf("lat edge%0d step", k), int'(step), 1);
        chk($sformatf("lat edge%0d last_value", k), int'(last_value), 2);
      end
    end
    @(posedge clk);
    #1;
    chk("lat step_width", int'(step), 0);

    // get a non-zero error count, then relock
    apply(mk(9, 1, 1, 0, 1, 0, 0, 9, 1, S_VER), "pre_rst_err");
    apply(mk(8, 1, 1, 0, 0, 0, 1, 8, 1, S_LCK), "pre_rst_lock");

    // asynchronous reset between clock edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
